fetch_pc_stage: RTL and testbench

//   F-stage PC register plus F->D pipeline register. Consumes next-PC from NPC, holds pc_F
//   (fed back to NPC and the IM), and latches instr/pc/exception code/delay-slot flag into D.

---
 rtl/fetch_pc_stage_pkg.sv | 35 +++
 rtl/fetch_pc_stage_if.sv | 34 +++
 rtl/fetch_pc_stage_fd_reg.sv | 39 +++
 rtl/fetch_pc_stage.sv | 98 +++++++++
 tb/tb_fetch_pc_stage.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_stage_pkg
//   Shared definitions for the fetch stage: default reset/handler PCs,
//   exception-code width and codes, the NOP encoding and the D-stage record.
// ---------------------------------------------------------------------------
package fetch_pc_stage_pkg;

    localparam int          EXC_W          = 5;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam logic [EXC_W-1:0] EXC_NONE  = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL  = 5'd4;

    // Contents of the F->D pipeline register.
    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [EXC_W-1:0] exc;
        logic             bd;
        logic             valid;
    } d_stage_t;

    // A bubble in D: no instruction, no exception, not a delay slot, not valid.
    function automatic d_stage_t make_bubble(input logic [31:0] pc);
        d_stage_t b;
        b.pc    = pc;
        b.instr = NOP_INSTR;
        b.exc   = EXC_NONE;
        b.bd    = 1'b0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_pc_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_stage_if
//   Bundle of control, fetch-side and D-stage signals of the fetch stage.
//   slave : the fetch stage (control/fetch inputs in, pc_F and D outputs out)
//   master: the surrounding pipeline / testbench
// ---------------------------------------------------------------------------
interface fetch_pc_stage_if;
    import fetch_pc_stage_pkg::*;

    logic             stall;
    logic             req;
    logic             eret_D;
    logic             branch_D;
    logic [31:0]      npc;
    logic [31:0]      instr_F;
    logic [EXC_W-1:0] exc_F;
    logic [31:0]      pc_F;
    logic [31:0]      pc_D;
    logic [31:0]      instr_D;
    logic [EXC_W-1:0] exc_D;
    logic             bd_D;
    logic             valid_D;

    modport slave (
        input  stall, req, eret_D, branch_D, npc, instr_F, exc_F,
        output pc_F, pc_D, instr_D, exc_D, bd_D, valid_D
    );

    modport master (
        output stall, req, eret_D, branch_D, npc, instr_F, exc_F,
        input  pc_F, pc_D, instr_D, exc_D, bd_D, valid_D
    );

endinterface

// File: rtl/fetch_pc_stage_fd_reg.sv
// ---------------------------------------------------------------------------
// fetch_pc_stage_fd_reg
//   F->D pipeline register. Flush beats enable: a flush loads a bubble
//   tagged with i_flush_pc; otherwise i_en loads i_d, else it holds.
//   Ports: i_clk, i_reset (async, active-low), i_en, i_flush, i_flush_pc,
//          i_d (next D record), o_q (registered D record).
// ---------------------------------------------------------------------------
module fetch_pc_stage_fd_reg
    import fetch_pc_stage_pkg::*;
#(
    parameter logic [31:0] P_RESET_PC = RESET_PC_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    input  d_stage_t    i_d,
    output d_stage_t    o_q
);

    d_stage_t r_q;

    // D-stage register: reset to a bubble at the reset PC, flush, load or hold.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_q <= make_bubble(P_RESET_PC);
        end else if (i_flush) begin
            r_q <= make_bubble(i_flush_pc);
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_pc_stage.sv
// ---------------------------------------------------------------------------
// fetch_pc_stage
//   Fetch PC register plus F->D pipeline register. Priority per edge:
//   req (redirect to handler, flush D) > stall (hold all) > eret_D (take
//   npc, bubble D) > normal (take npc, latch fetch into D).
//   Ports: i_clk, i_reset (async, active-low), bus (fetch_pc_stage_if.slave)
//          carrying stall/req/eret_D/branch_D/npc/instr_F/exc_F in and
//          pc_F/pc_D/instr_D/exc_D/bd_D/valid_D out. All outputs registered.
// ---------------------------------------------------------------------------
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    fetch_pc_stage_if.slave   bus
);

    logic [31:0] r_pc_F;
    logic        w_flush;
    logic [31:0] w_flush_pc;
    logic        w_en;
    d_stage_t    w_d_next;
    d_stage_t    w_d_q;

    // PC register: handler on req, hold on stall, otherwise follow npc.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc_F <= RESET_PC;
        end else if (bus.req) begin
            r_pc_F <= HANDLER_PC;
        end else if (bus.stall) begin
            r_pc_F <= r_pc_F;
        end else begin
            r_pc_F <= bus.npc;
        end
    end

    // D-register control: eret only kills F when the pipe is not stalled;
    // a req bubble carries the handler PC, an eret bubble the killed pc_F.
    always_comb begin
        w_flush    = 1'b0;
        w_flush_pc = r_pc_F;
        w_en       = 1'b0;
        if (bus.req) begin
            w_flush    = 1'b1;
            w_flush_pc = HANDLER_PC;
            w_en       = 1'b0;
        end else if (bus.stall) begin
            w_flush    = 1'b0;
            w_flush_pc = r_pc_F;
            w_en       = 1'b0;
        end else if (bus.eret_D) begin
            w_flush    = 1'b1;
            w_flush_pc = r_pc_F;
            w_en       = 1'b0;
        end else begin
            w_flush    = 1'b0;
            w_flush_pc = r_pc_F;
            w_en       = 1'b1;
        end
    end

    // Next D record; a faulting fetch enters D as NOP but keeps its code and bd flag.
    always_comb begin
        w_d_next.pc    = r_pc_F;
        w_d_next.exc   = bus.exc_F;
        w_d_next.bd    = bus.branch_D;
        w_d_next.valid = 1'b1;
        if (bus.exc_F != EXC_NONE) begin
            w_d_next.instr = NOP_INSTR;
        end else begin
            w_d_next.instr = bus.instr_F;
        end
    end

    fetch_pc_stage_fd_reg #(
        .P_RESET_PC (RESET_PC)
    ) u_fd_reg (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_en       (w_en),
        .i_flush    (w_flush),
        .i_flush_pc (w_flush_pc),
        .i_d        (w_d_next),
        .o_q        (w_d_q)
    );

    assign bus.pc_F    = r_pc_F;
    assign bus.pc_D    = w_d_q.pc;
    assign bus.instr_D = w_d_q.instr;
    assign bus.exc_D   = w_d_q.exc;
    assign bus.bd_D    = w_d_q.bd;
    assign bus.valid_D = w_d_q.valid;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_stage
//   Vector table of {inputs, expected outputs}; expected records are queued
//   when a vector is driven and popped/compared after the clock edge.
//   Extra hand-written sequences cover long stalls and async reset.
// ---------------------------------------------------------------------------
module tb_fetch_pc_stage;
    import fetch_pc_stage_pkg::*;

    typedef struct {
        logic        stall;
        logic        req;
        logic        eret;
        logic        br;
        logic [31:0] npc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic [31:0] e_pcf;
        logic [31:0] e_pcd;
        logic [31:0] e_instr;
        logic [4:0]  e_exc;
        logic        e_bd;
        logic        e_valid;
    } vec_t;

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] pcd;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
    } exp_t;

    localparam int NV = 15;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs [NV];
    exp_t exp_q [$];

    fetch_pc_stage_if bus ();

    fetch_pc_stage dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, req_v);
        end
    endtask

    task automatic pop_and_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            cmp({tag, ".pc_F"},    bus.pc_F,            e.pcf);
            cmp({tag, ".pc_D"},    bus.pc_D,            e.pcd);
            cmp({tag, ".instr_D"}, bus.instr_D,         e.instr);
            cmp({tag, ".exc_D"},   {27'd0, bus.exc_D},  {27'd0, e.exc});
            cmp({tag, ".bd_D"},    {31'd0, bus.bd_D},   {31'd0, e.bd});
            cmp({tag, ".valid_D"}, {31'd0, bus.valid_D}, {31'd0, e.valid});
        end
    endtask

    task automatic drive(input logic st, input logic rq, input logic er, input logic br,
                         input logic [31:0] npc, input logic [31:0] ins, input logic [4:0] ex);
        bus.stall    = st;
        bus.req      = rq;
        bus.eret_D   = er;
        bus.branch_D = br;
        bus.npc      = npc;
        bus.instr_F  = ins;
        bus.exc_F    = ex;
    endtask

    task automatic push_exp(input logic [31:0] pcf, input logic [31:0] pcd, input logic [31:0] ins,
                            input logic [4:0] ex, input logic bd, input logic vl);
        exp_t e;
        e.pcf = pcf; e.pcd = pcd; e.instr = ins; e.exc = ex; e.bd = bd; e.valid = vl;
        exp_q.push_back(e);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        pop_and_check(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //              st    rq    er    br    npc           instr         exc    pc_F          pc_D          instr_D       exc_D  bd    valid
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3004, 32'h2401_0001, 5'd0, 32'h0000_3004, 32'h0000_3000, 32'h2401_0001, 5'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3008, 32'h2402_0002, 5'd0, 32'h0000_3008, 32'h0000_3004, 32'h2402_0002, 5'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_300C, 32'h2403_0003, 5'd0, 32'h0000_3008, 32'h0000_3004, 32'h2402_0002, 5'd0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_3FFC, 32'h2403_0003, 5'd0, 32'h0000_3008, 32'h0000_3004, 32'h2402_0002, 5'd0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_300C, 32'h2403_0003, 5'd0, 32'h0000_300C, 32'h0000_3008, 32'h2403_0003, 5'd0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3010, 32'h2404_0004, 5'd0, 32'h0000_3010, 32'h0000_300C, 32'h2404_0004, 5'd0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3014, 32'h2405_0005, 5'd0, 32'h0000_4180, 32'h0000_4180, 32'h0000_0000, 5'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3014, 32'h1000_0003, 5'd0, 32'h0000_3014, 32'h0000_4180, 32'h1000_0003, 5'd0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3001, 32'h0000_0000, 5'd0, 32'h0000_3001, 32'h0000_3014, 32'h0000_0000, 5'd0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3020, 32'h8C01_0000, 5'd4, 32'h0000_3020, 32'h0000_3001, 32'h0000_0000, 5'd4, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3024, 32'h8C02_0000, 5'd4, 32'h0000_3024, 32'h0000_3020, 32'h0000_0000, 5'd4, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3030, 32'h2406_0006, 5'd0, 32'h0000_3030, 32'h0000_3024, 32'h0000_0000, 5'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3034, 32'h2407_0007, 5'd0, 32'h0000_3034, 32'h0000_3030, 32'h2407_0007, 5'd0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3038, 32'h2408_0008, 5'd3, 32'h0000_4180, 32'h0000_4180, 32'h0000_0000, 5'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3038, 32'h2408_0008, 5'd0, 32'h0000_3038, 32'h0000_4180, 32'h2408_0008, 5'd0, 1'b0, 1'b1};

        // Reset state before any clock edge.
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #12;
        push_exp(32'h0000_3000, 32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0);
        pop_and_check("reset");

        @(negedge clk);
        reset = 1'b1;

        // Vector table, one edge per record.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].req, vecs[i].eret, vecs[i].br,
                  vecs[i].npc, vecs[i].instr, vecs[i].exc);
            push_exp(vecs[i].e_pcf, vecs[i].e_pcd, vecs[i].e_instr,
                     vecs[i].e_exc, vecs[i].e_bd, vecs[i].e_valid);
            step($sformatf("vec%0d", i));
        end

        // Long stall: state frozen for 5 edges while npc/instr wander.
        for (int n = 0; n < 5; n++) begin
            drive(1'b1, 1'b0, n[0], 1'b1, 32'h0000_5000 + 32'(n * 4), 32'hDEAD_0000 + 32'(n), 5'd0);
            push_exp(32'h0000_3038, 32'h0000_4180, 32'h2408_0008, 5'd0, 1'b0, 1'b1);
            step($sformatf("stall%0d", n));
        end
        // Release: resume with npc presented at release.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_303C, 32'h2409_0009, 5'd0);
        push_exp(32'h0000_303C, 32'h0000_3038, 32'h2409_0009, 5'd0, 1'b0, 1'b1);
        step("stall_release");

        // Async reset asserted mid-cycle during a stall: takes effect without an edge.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3100, 32'h240A_000A, 5'd0);
        #2;
        reset = 1'b0;
        #1;
        push_exp(32'h0000_3000, 32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0);
        pop_and_check("async_reset");
        // Held through an edge with req pending: still reset values.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3100, 32'h240A_000A, 5'd0);
        push_exp(32'h0000_3000, 32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0);
        step("reset_held");

        // First edge after release loads normally from RESET_PC.
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3004, 32'h240B_000B, 5'd0);
        push_exp(32'h0000_3004, 32'h0000_3000, 32'h240B_000B, 5'd0, 1'b0, 1'b1);
        step("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
